addinc_pipe: RTL and testbench
==============================

ADDINC_PIPE -- requirements
Module: addinc_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and sum width; legal values are even numbers 4..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the operand set on this cycle is valid.
REQ-005 in_ready  output  1  the block accepts an operand set this cycle.
REQ-006 a, b  input  WIDTH each  operands, unsigned.
REQ-007 cin  input  1  carry-in.
REQ-008 inc  input  1  mode: 0 gives a+b+cin; 1 gives a+b+cin+1 (add-increment).
REQ-009 out_valid  output  1  the result is valid.
REQ-010 out_ready  input  1  the downstream accepts the result.
REQ-011 sum  output  WIDTH  result, modulo 2^WIDTH (or saturated, see REQ-026).
REQ-012 cout  output  2  carry count above bit WIDTH-1, range 0..2.
REQ-013 sat  output  1  the result was saturated.

Function
REQ-014 The full result SHALL be a+b+cin+inc, WIDTH+2 bits wide; sum holds bits [WIDTH-1:0] and cout holds bits [WIDTH+1:WIDTH].
REQ-015 The block SHALL be a 2-stage pipeline:
- Stage 1 adds the low WIDTH/2 bits with cin and inc, and registers the partial sum, the low carry (0..2) and the upper operand halves.
- Stage 2 adds the upper halves with the registered low carry.
REQ-016 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-017 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-018 A transfer SHALL occur on an input when in_valid && in_ready, and on an output when out_valid && out_ready.
REQ-019 in_ready SHALL equal !s1_valid || (!s2_valid || out_ready); it is combinational from out_ready, and there is no skid buffer.
REQ-020 Stage 2 SHALL load from stage 1 when !s2_valid || out_ready.
REQ-021 Stage 1 SHALL load on an input transfer. When stage 1 moves into stage 2 and no new input arrives, s1_valid SHALL clear.
REQ-022 While out_valid && !out_ready, sum, cout and sat SHALL hold stable, and no accepted operand set SHALL be lost or duplicated.
REQ-023 An input transfer and an output transfer in the same cycle SHALL both complete, with no bubble inserted.
REQ-024 Wrap-around: an overflowing result SHALL wrap modulo 2^WIDTH, with the overflow reported on cout, unless saturation applies.

Reset
REQ-025 rst high at a clock edge SHALL clear s1_valid and s2_valid, and force sum=0, cout=0 and sat=0.
- Data in flight is discarded.
- in_ready reads 1 on the first cycle after rst is released.
- rst has priority over every transfer in the same cycle.

Configuration
REQ-026 Macro ADDINC_SAT_EN controls saturation.
- When defined: if cout != 0, stage 2 SHALL output sum = all ones and sat = 1, and cout is still reported.
- When undefined: sum wraps and sat SHALL be constant 0.
- Latency and handshake SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-027 Basic add: a=0x12, b=0x34, cin=0, inc=0, out_ready=1 -> two cycles later sum=0x46, cout=0, sat=0.
REQ-028 Increment with wrap: a=0xFF, b=0xFF, cin=1, inc=1 -> sum=0x00, cout=2.
- With ADDINC_SAT_EN defined: sum=0xFF and sat=1 instead.
REQ-029 Backpressure: stream 4 sets of (a=i, b=1) while out_ready is low for 3 cycles in the middle.
- in_ready drops once both stages are full.
- The outputs are exactly 1, 2, 3, 4, in order, with no duplicates.
REQ-030 Full throughput: 16 back-to-back random sets with out_ready=1 -> 16 results on 16 consecutive cycles, each matching a golden a+b+cin+inc.
REQ-031 Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, sum=0, in_ready=1, and the first post-reset result matches the first post-reset input.
REQ-032 Simultaneous transfer: hold in_valid=1 and out_ready=1 with both stages full -> an input and an output are accepted in the same cycle, with no bubble.

Source files
------------

// File: rtl/addinc_pipe_if.sv
// Handshake and operand/result bundle for addinc_pipe.
// master drives operands and out_ready; slave is the adder pipeline.
interface addinc_pipe_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             inc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [1:0]       cout;
    logic             sat;

    modport master (
        output in_valid, a, b, cin, inc, out_ready,
        input  in_ready, out_valid, sum, cout, sat
    );

    modport slave (
        input  in_valid, a, b, cin, inc, out_ready,
        output in_ready, out_valid, sum, cout, sat
    );
endinterface

// File: rtl/addinc_pipe.sv
// Two-stage add/add-increment pipeline: sum = a + b + cin + inc, split at WIDTH/2.
// Define ADDINC_SAT_EN to saturate sum to all ones whenever cout is non-zero.
module addinc_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    addinc_pipe_if.slave bus
);
    localparam int unsigned HALF = WIDTH / 2;

    logic            s1_valid;
    logic [HALF-1:0] s1_lo;
    logic [1:0]      s1_c;
    logic [HALF-1:0] s1_ah;
    logic [HALF-1:0] s1_bh;

    logic             s2_valid;
    logic [WIDTH-1:0] sum_q;
    logic [1:0]       cout_q;

    logic [HALF+1:0] lo_full;
    logic [HALF+1:0] hi_full;
    logic            s2_load;
    logic            in_fire;

    // Two spare bits: low half plus cin plus inc can carry up to 2.
    always_comb begin
        lo_full = {2'b00, bus.a[HALF-1:0]} + {2'b00, bus.b[HALF-1:0]}
                + {{(HALF + 1){1'b0}}, bus.cin} + {{(HALF + 1){1'b0}}, bus.inc};
        hi_full = {2'b00, s1_ah} + {2'b00, s1_bh} + {{HALF{1'b0}}, s1_c};
    end

    assign s2_load       = !s2_valid || bus.out_ready;
    assign bus.in_ready  = !s1_valid || s2_load;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef ADDINC_SAT_EN
    logic sat_q;
    assign bus.sat = sat_q;
`else
    assign bus.sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 2'b00;
`ifdef ADDINC_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_full[HALF-1:0];
                s1_c     <= lo_full[HALF+1:HALF];
                s1_ah    <= bus.a[WIDTH-1:HALF];
                s1_bh    <= bus.b[WIDTH-1:HALF];
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            // Result registers only change on a real load, so they hold under backpressure.
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    cout_q <= hi_full[HALF+1:HALF];
`ifdef ADDINC_SAT_EN
                    if (hi_full[HALF+1:HALF] != 2'b00) begin
                        sum_q <= '1;
                        sat_q <= 1'b1;
                    end else begin
                        sum_q <= {hi_full[HALF-1:0], s1_lo};
                        sat_q <= 1'b0;
                    end
`else
                    sum_q  <= {hi_full[HALF-1:0], s1_lo};
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_addinc_pipe.sv
// Directed self-checking bench for addinc_pipe at WIDTH=8.
// Honours ADDINC_SAT_EN for the saturating expectations.
module tb_addinc_pipe;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    addinc_pipe_if #(.WIDTH(WIDTH)) bus ();

    addinc_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic inc, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.inc       = inc;
        bus.out_ready = ordy;
    endtask

    // Golden {sat, cout, sum} for the random stream.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic inc);
        logic [9:0] full;
        full = {2'b00, a} + {2'b00, b} + {9'd0, cin} + {9'd0, inc};
`ifdef ADDINC_SAT_EN
        if (full[9:8] != 2'b00) return {1'b1, full[9:8], 8'hFF};
`endif
        return {1'b0, full};
    endfunction

    initial begin
        logic [7:0]  ra, rb;
        logic        rc, ri;
        logic [10:0] expq[$];
        logic [10:0] e;
        logic [7:0]  got[$];
        logic [7:0]  held;
        logic        stalled;
        bit          saw_block;
        bit          ready_ok;
        int          sent, recv, first_c, last_c;

        n_cmp = 0;
        n_err = 0;

        // Reset
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_sum", 32'(bus.sum), 32'd0);
        chk("reset_cout", 32'(bus.cout), 32'd0);
        chk("reset_sat", 32'(bus.sat), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add: 0x12 + 0x34 = 0x46, two-cycle latency
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("basic_lat1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_sum", 32'(bus.sum), 32'h46);
        chk("basic_cout", 32'(bus.cout), 32'd0);
        chk("basic_sat", 32'(bus.sat), 32'd0);
        tick();
        chk("basic_drain", 32'(bus.out_valid), 32'd0);

        // 0xFF + 0xFF + 1 + 1 = 0x200
        drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("wrap_valid", 32'(bus.out_valid), 32'd1);
        chk("wrap_cout", 32'(bus.cout), 32'd2);
`ifdef ADDINC_SAT_EN
        chk("wrap_sum", 32'(bus.sum), 32'hFF);
        chk("wrap_sat", 32'(bus.sat), 32'd1);
`else
        chk("wrap_sum", 32'(bus.sum), 32'h00);
        chk("wrap_sat", 32'(bus.sat), 32'd0);
`endif
        tick();

        // Backpressure: a=i, b=1 for i=0..3, out_ready low for cycles 2..4
        sent = 0;
        saw_block = 1'b0;
        stalled = 1'b0;
        held = 8'h00;
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            drive(sent < 4, 8'(sent), 8'h01, 1'b0, 1'b0, !(c >= 2 && c < 5));
            #1;
            if (!bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid && !bus.out_ready) begin
                if (stalled) chk("bp_hold_sum", 32'(bus.sum), 32'(held));
                held = bus.sum;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.sum);
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("bp_in_ready_dropped", 32'(saw_block), 32'd1);
        chk("bp_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("bp_order", 32'(got[i]), 32'(i + 1));
        tick();
        chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

        // Full throughput: 16 random sets back to back
        sent = 0;
        recv = 0;
        first_c = -1;
        last_c = -1;
        ready_ok = 1'b1;
        for (int c = 0; c < 40 && recv < 16; c++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ri = 1'($urandom);
            drive(sent < 16, ra, rb, rc, ri, 1'b1);
            #1;
            if (!bus.in_ready) ready_ok = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(ra, rb, rc, ri));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : 11'h7FF;
                chk("tp_result", {21'd0, bus.sat, bus.cout, bus.sum}, {21'd0, e});
                if (first_c < 0) first_c = c;
                last_c = c;
                recv++;
            end
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("tp_count", 32'(recv), 32'd16);
        chk("tp_consecutive", 32'(last_c - first_c), 32'd15);
        chk("tp_in_ready", 32'(ready_ok), 32'd1);
        tick();
        tick();

        // Reset mid-stream with both stages full
        drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rs_full_valid", 32'(bus.out_valid), 32'd1);
        chk("rs_full_blocked", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        drive(1'b1, 8'h09, 8'h09, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_sum", 32'(bus.sum), 32'd0);
        chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'h05, 8'h07, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rs_lat1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("rs_first_valid", 32'(bus.out_valid), 32'd1);
        chk("rs_first_sum", 32'(bus.sum), 32'h0D);
        tick();
        chk("rs_drain", 32'(bus.out_valid), 32'd0);

        // Simultaneous input and output transfer with both stages full
        drive(1'b1, 8'd10, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'd20, 8'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'd30, 8'd1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("sim_in_ready", 32'(bus.in_ready), 32'd1);
        chk("sim_out_valid", 32'(bus.out_valid), 32'd1);
        chk("sim_sum0", 32'(bus.sum), 32'h0B);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("sim_no_bubble", 32'(bus.out_valid), 32'd1);
        chk("sim_sum1", 32'(bus.sum), 32'h15);
        tick();
        chk("sim_valid2", 32'(bus.out_valid), 32'd1);
        chk("sim_sum2", 32'(bus.sum), 32'h1F);
        tick();
        chk("sim_drain", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
